renkon_conv_wbuf: RTL and testbench
===================================

# renkon_conv_wbuf

Parametrised weight-register bank for the renkon convolution core, generalising the fixed 25-tap weight shift chain to an arbitrary FSIZE×FSIZE kernel. Weights stream in one per write strobe from the weight memory read port. A load counter and FSM track fill state. An optional shadow bank lets the next kernel load while the current kernel drives the MAC array. It sits between the weight memory and the renkon convolution datapath.

## Interface
- DWIDTH, 16, signed weight word width
- FSIZE, 5, kernel edge; tap count N = FSIZE*FSIZE (range 1..11)
- CWIDTH, 7, load-counter width; must satisfy 2**CWIDTH > N
- clk  input  1  clock; all state updates on rising edge
- xrst  input  1  asynchronous active-low reset
- wreg_we  input  1  write strobe; shifts read_weight into the load chain
- read_weight  input  DWIDTH  signed weight word
- wreg_clear  input  1  abort current load; counter to 0
- wreg_swap  input  1  request to commit the loaded kernel to the active bank
- weight  output  DWIDTH*N  flat active kernel; tap i at [DWIDTH*(i+1)-1 : DWIDTH*i]
- wreg_full  output  1  load chain holds N fresh words
- wreg_ovf  output  1  one-cycle pulse: write dropped because chain full
- wreg_cnt  output  CWIDTH  words loaded since last clear/swap

## Operation
- Load chain L[0..N-1]: on an accepted write, L[i] <= L[i+1] for i<N-1, L[N-1] <= read_weight. The first word written ends in L[0] after N writes.
- Active bank A[0..N-1] drives weight.
- FSM states: EMPTY (cnt=0), LOADING (0<cnt<N), FULL (cnt=N).
  - EMPTY/LOADING + wreg_we: write accepted, cnt+1. Reaching N goes to FULL.
  - FULL + wreg_we: write dropped, L and cnt unchanged, wreg_ovf=1 for that cycle.
  - FULL + wreg_swap: A <= L, cnt <= 0, go to EMPTY. L is retained.
  - wreg_swap outside FULL: ignored, no state change.
  - wreg_clear in any state: cnt <= 0, go to EMPTY. L and A are unchanged.
- Priority within one cycle: wreg_clear > wreg_swap > wreg_we.
  - Swap+write while FULL: swap taken; the write is dropped with no ovf pulse.
  - Clear+write: clear taken; the write is dropped.
- A changes only on an accepted swap. Writes never disturb weight.
- Arithmetic: no weight arithmetic; words pass through bit-exact, signed.

## Timing
- All outputs are registered. Reset values: weight=0, wreg_full=0, wreg_ovf=0, wreg_cnt=0. L, A and FSM are all cleared to 0/EMPTY.
- Write at edge t: wreg_cnt and L are updated after edge t. wreg_full rises after the Nth write edge.
- Swap accepted at edge t: weight shows the new kernel and wreg_full=0 from t+1. Latency is one cycle.
- wreg_ovf is high exactly for the cycle after the dropped-write edge.
- Back-to-back writes at one per cycle are fully supported. A new load may begin the cycle after swap.
- xrst asserted mid-load or mid-swap: immediate return to reset values. Partial loads are discarded.

## Configuration
- RENKON_WBUF_DBUF_EN defined: double-buffered as above, with separate L and A.
- Undefined: single bank; A is not instantiated and weight = L directly (legacy behaviour).
  - Writes are visible on weight one cycle after each accepted write.
  - wreg_swap only resets cnt to 0 and returns to EMPTY when FULL.
  - Overflow and clear behaviour are unchanged.

## Test plan
- Reset: hold xrst=0 for 3 cycles → weight=0, wreg_cnt=0, wreg_full=0, wreg_ovf=0.
- Load-and-swap (FSIZE=5): write 1..25 on consecutive cycles → wreg_full=1, cnt=25, weight still 0. Pulse swap → next cycle tap0=1 … tap24=25, full=0, cnt=0.
- Overflow: after 25 writes, write 99 → wreg_ovf=1 for one cycle, cnt stays 25. After swap, tap24=25 (99 absent).
- Early swap and clear: write 10 words, pulse swap → ignored, cnt=10. Pulse clear → cnt=0. Write 25 words −1..−25, swap → tap0=−1, tap24=−25.
- Shadow isolation (DBUF_EN): with kernel 1..25 active, load 101..125 → weight unchanged until swap, then tap0=101.
- Reset mid-load: after 12 writes, assert xrst → all outputs 0. Then a full 25-word load plus swap behaves as the load-and-swap scenario.

Source files
------------

// File: rtl/renkon_conv_wbuf.sv
// Weight-register bank for the renkon convolution core: FSIZE*FSIZE load chain with fill-tracking FSM.
// Define RENKON_WBUF_DBUF_EN for a separate active (shadow-swapped) bank; otherwise weight is the load chain.
module renkon_conv_wbuf #(
    parameter int DWIDTH = 16,
    parameter int FSIZE  = 5,
    parameter int CWIDTH = 7
) (
    input  logic                             clk,
    input  logic                             xrst,
    input  logic                             wreg_we,
    input  logic [DWIDTH-1:0]                read_weight,
    input  logic                             wreg_clear,
    input  logic                             wreg_swap,
    output logic [DWIDTH*FSIZE*FSIZE-1:0]    weight,
    output logic                             wreg_full,
    output logic                             wreg_ovf,
    output logic [CWIDTH-1:0]                wreg_cnt
);

    localparam int N = FSIZE * FSIZE;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CWIDTH-1:0]   cnt, cnt_nxt;
    logic                accept;
    logic                ovf_nxt;
    logic signed [DWIDTH-1:0] lchain [N];
`ifdef RENKON_WBUF_DBUF_EN
    logic                swap_acc;
    logic signed [DWIDTH-1:0] abank [N];
`endif

    // Priority: clear, then a swap taken only when full, then a write.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        ovf_nxt   = 1'b0;
`ifdef RENKON_WBUF_DBUF_EN
        swap_acc  = 1'b0;
`endif
        if (wreg_clear) begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
        end else if (wreg_swap && state == FULL) begin
`ifdef RENKON_WBUF_DBUF_EN
            swap_acc  = 1'b1;
`endif
            state_nxt = EMPTY;
            cnt_nxt   = '0;
        end else if (wreg_we) begin
            case (state)
                FULL: ovf_nxt = 1'b1;
                default: begin
                    accept    = 1'b1;
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = (cnt_nxt == CWIDTH'(N)) ? FULL : LOADING;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state    <= EMPTY;
            cnt      <= '0;
            wreg_ovf <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wreg_ovf <= ovf_nxt;
        end
    end

    // Load chain: oldest word drifts toward tap 0.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < N; i++) lchain[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N - 1; i++) lchain[i] <= lchain[i+1];
            lchain[N-1] <= read_weight;
        end
    end

`ifdef RENKON_WBUF_DBUF_EN
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < N; i++) abank[i] <= '0;
        end else if (swap_acc) begin
            for (int i = 0; i < N; i++) abank[i] <= lchain[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) weight[DWIDTH*i +: DWIDTH] = abank[i];
    end
`else
    always_comb begin
        for (int i = 0; i < N; i++) weight[DWIDTH*i +: DWIDTH] = lchain[i];
    end
`endif

    assign wreg_full = (state == FULL);
    assign wreg_cnt  = cnt;

endmodule

// File: tb/tb_renkon_conv_wbuf.sv
// Self-checking bench for renkon_conv_wbuf: directed scenarios followed by random traffic against a queue-based model.
module tb_renkon_conv_wbuf;

    localparam int DWIDTH = 16;
    localparam int FSIZE  = 5;
    localparam int CWIDTH = 7;
    localparam int N      = FSIZE * FSIZE;
    localparam int WW     = DWIDTH * N;
`ifdef RENKON_WBUF_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              xrst = 1'b0;
    logic              wreg_we = 1'b0;
    logic [DWIDTH-1:0] read_weight = '0;
    logic              wreg_clear = 1'b0;
    logic              wreg_swap = 1'b0;
    logic [WW-1:0]     weight;
    logic              wreg_full;
    logic              wreg_ovf;
    logic [CWIDTH-1:0] wreg_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: L and A as plain word lists, fill count, last ovf.
    logic [DWIDTH-1:0] m_l[$];
    logic [DWIDTH-1:0] m_a[$];
    int                m_cnt;
    bit                m_ovf;

    renkon_conv_wbuf #(.DWIDTH(DWIDTH), .FSIZE(FSIZE), .CWIDTH(CWIDTH)) dut (
        .clk(clk), .xrst(xrst), .wreg_we(wreg_we), .read_weight(read_weight),
        .wreg_clear(wreg_clear), .wreg_swap(wreg_swap), .weight(weight),
        .wreg_full(wreg_full), .wreg_ovf(wreg_ovf), .wreg_cnt(wreg_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DWIDTH-1:0] tap(input int i);
        return weight[DWIDTH*i +: DWIDTH];
    endfunction

    task automatic model_reset();
        m_l.delete();
        m_a.delete();
        for (int i = 0; i < N; i++) begin
            m_l.push_back('0);
            m_a.push_back('0);
        end
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [WW-1:0] expw;
        for (int i = 0; i < N; i++) expw[DWIDTH*i +: DWIDTH] = DBUF ? m_a[i] : m_l[i];
        check({tag, ".weight"}, weight, expw);
        check({tag, ".cnt"}, WW'(wreg_cnt), WW'(m_cnt));
        check({tag, ".full"}, WW'(wreg_full), WW'(m_cnt == N));
        check({tag, ".ovf"}, WW'(wreg_ovf), WW'(m_ovf));
    endtask

    // One clock with the given strobes; model follows the clear > swap > write rules.
    task automatic cycle(input string tag, input bit we, input logic [DWIDTH-1:0] d,
                         input bit clr, input bit swp);
        wreg_we = we; read_weight = d; wreg_clear = clr; wreg_swap = swp;
        @(posedge clk);
        m_ovf = 1'b0;
        if (clr) begin
            m_cnt = 0;
        end else if (swp && m_cnt == N) begin
            if (DBUF) m_a = m_l;
            m_cnt = 0;
        end else if (we) begin
            if (m_cnt == N) m_ovf = 1'b1;
            else begin
                void'(m_l.pop_front());
                m_l.push_back(d);
                m_cnt++;
            end
        end
        #1;
        wreg_we = 1'b0; wreg_clear = 1'b0; wreg_swap = 1'b0;
        check_all(tag);
    endtask

    task automatic load_seq(input string tag, input int first, input int step);
        for (int k = 0; k < N; k++) cycle(tag, 1'b1, DWIDTH'(first + step * k), 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.weight", weight, '0);
        check("rst.cnt", WW'(wreg_cnt), '0);
        check("rst.full", WW'(wreg_full), '0);
        check("rst.ovf", WW'(wreg_ovf), '0);
        @(negedge clk);
        xrst = 1'b1;

        // Load 1..25 and swap
        load_seq("load1", 1, 1);
        check("load1.full", WW'(wreg_full), WW'(1));
        check("load1.cnt", WW'(wreg_cnt), WW'(25));
`ifdef RENKON_WBUF_DBUF_EN
        check("load1.wstill0", weight, '0);
`endif
        cycle("ovf", 1'b1, 16'd99, 1'b0, 1'b0);
        check("ovf.pulse", WW'(wreg_ovf), WW'(1));
        check("ovf.cnt", WW'(wreg_cnt), WW'(25));
        cycle("ovf.idle", 1'b0, '0, 1'b0, 1'b0);
        check("ovf.drop", WW'(wreg_ovf), WW'(0));
        cycle("swap1", 1'b0, '0, 1'b0, 1'b1);
        check("swap1.tap0", WW'(tap(0)), WW'(16'd1));
        check("swap1.tap24", WW'(tap(24)), WW'(16'd25));
        check("swap1.full", WW'(wreg_full), WW'(0));

        // Early swap ignored, clear, then a negative kernel
        for (int k = 0; k < 10; k++) cycle("early", 1'b1, DWIDTH'(200 + k), 1'b0, 1'b0);
        cycle("early.swap", 1'b0, '0, 1'b0, 1'b1);
        check("early.cnt", WW'(wreg_cnt), WW'(10));
        cycle("clear", 1'b0, '0, 1'b1, 1'b0);
        check("clear.cnt", WW'(wreg_cnt), WW'(0));
        load_seq("neg", -1, -1);
        cycle("neg.swap", 1'b0, '0, 1'b0, 1'b1);
        check("neg.tap0", WW'(tap(0)), WW'(16'hFFFF));
        check("neg.tap24", WW'(tap(24)), WW'(16'hFFE7));

        // Shadow isolation and swap+write / clear+write collisions
        load_seq("k1", 1, 1);
        cycle("k1.swapwr", 1'b1, 16'd77, 1'b0, 1'b1);
        check("k1.swapwr.ovf", WW'(wreg_ovf), WW'(0));
        load_seq("k2", 101, 1);
`ifdef RENKON_WBUF_DBUF_EN
        check("shadow.tap0", WW'(tap(0)), WW'(16'd1));
`endif
        cycle("k2.swap", 1'b0, '0, 1'b0, 1'b1);
        check("k2.tap0", WW'(tap(0)), WW'(16'd101));
        cycle("clrwr", 1'b1, 16'd55, 1'b1, 1'b0);
        check("clrwr.cnt", WW'(wreg_cnt), WW'(0));

        // Reset in the middle of a load
        for (int k = 0; k < 12; k++) cycle("mid", 1'b1, DWIDTH'(300 + k), 1'b0, 1'b0);
        #2 xrst = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        xrst = 1'b1;
        load_seq("reload", 1, 1);
        cycle("reload.swap", 1'b0, '0, 1'b0, 1'b1);
        check("reload.tap0", WW'(tap(0)), WW'(16'd1));
        check("reload.tap24", WW'(tap(24)), WW'(16'd25));

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cycle("rand", r < 75, DWIDTH'($urandom), r >= 97, (r >= 60 && r < 72) || r == 96);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
